// File: rtl/commit_req_arbiter_if.sv
// Bundle of requester, commit-engine and response signals around commit_req_arbiter.
// master = arbiter side, slave = requesters / commit engine side.
interface commit_req_arbiter_if #(
  parameter int unsigned DW     = 32,
  parameter int unsigned OUTSTD = 4
);
  localparam int unsigned OW = $clog2(OUTSTD) + 1;

  logic          s0_req_vaild;
  logic          s0_req_ready;
  logic [DW-1:0] s0_req_data;
  logic          s0_req_wr;
  logic          s1_req_vaild;
  logic          s1_req_ready;
  logic [DW-1:0] s1_req_data;
  logic          s1_req_wr;

  logic          req_vaild;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic          req_wr;
  logic          req_src;

  logic          rsp_vaild;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  logic          s0_rsp_vaild;
  logic          s0_rsp_ready;
  logic [DW-1:0] s0_rsp_data;
  logic          s1_rsp_vaild;
  logic          s1_rsp_ready;
  logic [DW-1:0] s1_rsp_data;

  logic [OW-1:0] outstanding;
  logic          rsp_err;

  modport master (
    input  s0_req_vaild, s0_req_data, s0_req_wr,
    input  s1_req_vaild, s1_req_data, s1_req_wr,
    output s0_req_ready, s1_req_ready,
    output req_vaild, req_data, req_wr, req_src,
    input  req_ready,
    input  rsp_vaild, rsp_data,
    output rsp_ready,
    output s0_rsp_vaild, s0_rsp_data, s1_rsp_vaild, s1_rsp_data,
    input  s0_rsp_ready, s1_rsp_ready,
    output outstanding, rsp_err
  );

  modport slave (
    output s0_req_vaild, s0_req_data, s0_req_wr,
    output s1_req_vaild, s1_req_data, s1_req_wr,
    input  s0_req_ready, s1_req_ready,
    input  req_vaild, req_data, req_wr, req_src,
    output req_ready,
    output rsp_vaild, rsp_data,
    input  rsp_ready,
    input  s0_rsp_vaild, s0_rsp_data, s1_rsp_vaild, s1_rsp_data,
    output s0_rsp_ready, s1_rsp_ready,
    input  outstanding, rsp_err
  );
endinterface

// File: rtl/commit_req_arbiter.sv
// Two-requester arbiter for the DDR commit req/rsp channel: weighted grant toward s0,
// registered request stage, and an in-order owner-tag FIFO that routes responses back.
module commit_req_arbiter #(
  parameter int unsigned DW     = 32,
  parameter int unsigned OUTSTD = 4,
  parameter int unsigned W0     = 2
) (
  input logic                  clk,
  input logic                  reset,
  commit_req_arbiter_if.master bus
);
  localparam int unsigned PW = $clog2(OUTSTD);
  localparam int unsigned OW = PW + 1;
  localparam int unsigned CW = $clog2(W0 + 1);

  logic              req_vaild_q, req_vaild_d;
  logic [DW-1:0]     req_data_q,  req_data_d;
  logic              req_wr_q,    req_wr_d;
  logic              req_src_q,   req_src_d;
  logic [CW-1:0]     cnt0_q,      cnt0_d;
  logic [OUTSTD-1:0] tags_q,      tags_d;
  logic [PW-1:0]     wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q,    rd_ptr_d;
  logic [OW-1:0]     occ_q,       occ_d;
  logic              rsp_err_q,   rsp_err_d;

  logic slot_free_c, pick1_c, push_c, pop_c, empty_c, head_c;
  logic rsp_ready_c, s0_rsp_vaild_c, s1_rsp_vaild_c;

  // Grant and capture; comb handshake outputs are masked while reset is held.
  always_comb begin
    slot_free_c = (!req_vaild_q || bus.req_ready) && (occ_q < OW'(OUTSTD));
    pick1_c     = bus.s1_req_vaild && (!bus.s0_req_vaild || (cnt0_q >= CW'(W0)));
    push_c      = reset && slot_free_c && (bus.s0_req_vaild || bus.s1_req_vaild);

    req_vaild_d = req_vaild_q;
    req_data_d  = req_data_q;
    req_wr_d    = req_wr_q;
    req_src_d   = req_src_q;
    cnt0_d      = cnt0_q;
    if (push_c) begin
      req_vaild_d = 1'b1;
      req_src_d   = pick1_c;
      req_data_d  = pick1_c ? bus.s1_req_data : bus.s0_req_data;
      req_wr_d    = pick1_c ? bus.s1_req_wr   : bus.s0_req_wr;
      if (bus.s0_req_vaild && bus.s1_req_vaild && !pick1_c) begin
        cnt0_d = cnt0_q + CW'(1);
      end else begin
        cnt0_d = '0;
      end
    end else if (bus.req_ready) begin
      req_vaild_d = 1'b0;
    end
  end

  // Response routing from the head tag; an empty FIFO swallows the response and flags it.
  always_comb begin
    empty_c        = (occ_q == '0);
    head_c         = tags_q[rd_ptr_q];
    rsp_ready_c    = 1'b0;
    s0_rsp_vaild_c = 1'b0;
    s1_rsp_vaild_c = 1'b0;
    pop_c          = 1'b0;
    rsp_err_d      = rsp_err_q;
    if (reset) begin
      if (empty_c) begin
        rsp_ready_c = 1'b1;
        if (bus.rsp_vaild) rsp_err_d = 1'b1;
      end else begin
        if (head_c) begin
          s1_rsp_vaild_c = bus.rsp_vaild;
          rsp_ready_c    = bus.s1_rsp_ready;
        end else begin
          s0_rsp_vaild_c = bus.rsp_vaild;
          rsp_ready_c    = bus.s0_rsp_ready;
        end
        pop_c = bus.rsp_vaild && rsp_ready_c;
      end
    end
  end

  // Tag FIFO bookkeeping; a same-cycle push and pop leave occupancy unchanged.
  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_c) begin
      tags_d[wr_ptr_q] = pick1_c;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_vaild_q <= 1'b0;
      req_data_q  <= '0;
      req_wr_q    <= 1'b0;
      req_src_q   <= 1'b0;
      cnt0_q      <= '0;
      tags_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      req_vaild_q <= req_vaild_d;
      req_data_q  <= req_data_d;
      req_wr_q    <= req_wr_d;
      req_src_q   <= req_src_d;
      cnt0_q      <= cnt0_d;
      tags_q      <= tags_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.s0_req_ready = push_c && !pick1_c;
  assign bus.s1_req_ready = push_c && pick1_c;
  assign bus.req_vaild    = req_vaild_q;
  assign bus.req_data     = req_data_q;
  assign bus.req_wr       = req_wr_q;
  assign bus.req_src      = req_src_q;
  assign bus.rsp_ready    = rsp_ready_c;
  assign bus.s0_rsp_vaild = s0_rsp_vaild_c;
  assign bus.s1_rsp_vaild = s1_rsp_vaild_c;
  assign bus.s0_rsp_data  = bus.rsp_data;
  assign bus.s1_rsp_data  = bus.rsp_data;
  assign bus.outstanding  = occ_q;
  assign bus.rsp_err      = rsp_err_q;
endmodule
